// File: rtl/qei_pkg.sv
// Shared types and constants for the encoder input conditioning stage.
package qei_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } enc_filt_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/enc_input_filter_if.sv
// Pin-side bundle of the encoder input filter: raw encoder pins in, clean levels and error flags out.
// Handshake: there is no valid/ready flow control; every signal is a level sampled on each clk rising edge.
interface enc_input_filter_if;

  logic enc_a_raw;
  logic enc_b_raw;
  logic err_clr;
  logic enc_a;
  logic enc_b;
  logic ready;
  logic err_pulse;
  logic err_sticky;

  modport master (
    output enc_a_raw, enc_b_raw, err_clr,
    input  enc_a, enc_b, ready, err_pulse, err_sticky
  );

  modport slave (
    input  enc_a_raw, enc_b_raw, err_clr,
    output enc_a, enc_b, ready, err_pulse, err_sticky
  );

endinterface

// File: rtl/enc_chan_filter.sv
// One encoder channel: 2-flop synchroniser followed by a stability counter that
// commits a new level only after it has been seen for STABLE_CYCLES consecutive samples.
module enc_chan_filter
  import qei_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic raw,
  output logic level_out,
  output logic commit
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 s1_q;
  logic                 s2_q;
  logic                 level_q;
  logic                 level_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // While not running the level shadows s2, so the last INIT edge loads the
  // synchronised pin value; the top masks it until ready is set.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    commit  = 1'b0;
    if (!run) begin
      level_d = s2_q;
    end else if (s2_q != level_q) begin
      if (cnt_q == LAST_CNT) begin
        level_d = s2_q;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/enc_input_filter.sv
// Encoder front end: two filtered channels, an INIT/RUN sequencer that loads the
// initial pin levels, and detection of illegal simultaneous A/B transitions.
module enc_input_filter
  import qei_pkg::*;
#(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_WIDTH     = $clog2(STABLE_CYCLES + 3)
) (
  input  logic clk,
  input  logic nrst,
  input  logic enc_a_raw,
  input  logic enc_b_raw,
  input  logic err_clr,
  output logic enc_a,
  output logic enc_b,
  output logic ready,
  output logic err_pulse,
  output logic err_sticky
);

  localparam logic [CNT_WIDTH-1:0] LOAD_CNT = CNT_WIDTH'(STABLE_CYCLES + 1);

  enc_filt_state_t      state_q;
  enc_filt_state_t      state_d;
  logic [CNT_WIDTH-1:0] init_cnt_q;
  logic [CNT_WIDTH-1:0] init_cnt_d;
  logic                 ready_q;
  logic                 ready_d;
  logic                 err_pulse_q;
  logic                 err_pulse_d;
  logic                 err_sticky_q;
  logic                 err_sticky_d;

  logic run;
  logic lvl_a;
  logic lvl_b;
  logic commit_a;
  logic commit_b;
  logic double_commit;

  assign run = (state_q == RUN);

  enc_chan_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_chan_a (
    .clk       (clk),
    .nrst      (nrst),
    .run       (run),
    .raw       (enc_a_raw),
    .level_out (lvl_a),
    .commit    (commit_a)
  );

  enc_chan_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_chan_b (
    .clk       (clk),
    .nrst      (nrst),
    .run       (run),
    .raw       (enc_b_raw),
    .level_out (lvl_b),
    .commit    (commit_b)
  );

  assign double_commit = commit_a & commit_b;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      ready_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      ready_q      <= ready_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    ready_d      = ready_q;
    err_pulse_d  = double_commit;
    err_sticky_d = err_sticky_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + CNT_WIDTH'(1);
        if (init_cnt_q == LOAD_CNT) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
    // A new illegal transition takes priority over a clear on the same edge.
    if (double_commit) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  // Channel levels track the pins during INIT; hold the outputs low until loaded.
  assign enc_a      = ready_q & lvl_a;
  assign enc_b      = ready_q & lvl_b;
  assign ready      = ready_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

endmodule
